// File: rtl/bin_to_gray_enc.sv
// Streaming binary-to-Gray encoder with valid/ready on both sides.
// One registered output stage backed by a one-entry skid buffer, so in_ready
// is a pure register output and never depends on out_ready. Each accepted
// beat is checked for being a +/-1 (mod 2^WIDTH) step from the previous
// accepted beat, which is what a Gray-coded pointer needs before it crosses
// a clock domain.
module bin_to_gray_enc #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_step_err,
  output logic             out_wrap,
  output logic [ERRW-1:0]  err_count
);

  localparam logic [WIDTH-1:0] BIN_ZERO = '0;
  localparam logic [WIDTH-1:0] BIN_ONES = '1;
  localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);
  localparam logic [ERRW-1:0]  ERR_ONE  = ERRW'(1);
  localparam logic [ERRW-1:0]  ERR_MAX  = '1;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
    return (c == ERR_MAX) ? c : c + ERR_ONE;
  endfunction

  logic             skid_valid;
  logic [WIDTH-1:0] skid_gray;
  logic             skid_step_err;
  logic             skid_wrap;
  logic             hist_valid;
  logic [WIDTH-1:0] prev_bin;

  logic             acc;
  logic             xfer;
  logic [WIDTH-1:0] gray_p0;
  logic             step_err_p0;
  logic             wrap_p0;

  assign in_ready = !skid_valid;
  assign acc      = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Stage p0: encode the incoming value and classify its step against history.
  always_comb begin
    gray_p0     = to_gray(in_bin);
    step_err_p0 = 1'b0;
    wrap_p0     = 1'b0;
    if (hist_valid) begin
      step_err_p0 = !((in_bin == prev_bin + BIN_ONE) || (in_bin == prev_bin - BIN_ONE));
      wrap_p0     = ((prev_bin == BIN_ONES) && (in_bin == BIN_ZERO)) ||
                    ((prev_bin == BIN_ZERO) && (in_bin == BIN_ONES));
    end
  end

  // History-valid flag and saturating error counter, updated at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_valid <= 1'b0;
      err_count  <= '0;
    end else if (acc) begin
      hist_valid <= 1'b1;
      if (step_err_p0) err_count <= sat_inc(err_count);
    end
  end

  // Previous-value history and skid payload; qualified by their valid flags.
  always_ff @(posedge clk) begin
    if (acc) prev_bin <= in_bin;
    if (acc && out_valid && !out_ready) begin
      skid_gray     <= gray_p0;
      skid_step_err <= step_err_p0;
      skid_wrap     <= wrap_p0;
    end
  end

  // Stage p1: output register and skid occupancy. The skid drains first so
  // order is kept; a new beat can only arrive while the skid is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_gray     <= '0;
      out_step_err <= 1'b0;
      out_wrap     <= 1'b0;
      skid_valid   <= 1'b0;
    end else if (skid_valid) begin
      if (xfer) begin
        out_gray     <= skid_gray;
        out_step_err <= skid_step_err;
        out_wrap     <= skid_wrap;
        skid_valid   <= 1'b0;
      end
    end else if (acc) begin
      if (!out_valid || out_ready) begin
        out_valid    <= 1'b1;
        out_gray     <= gray_p0;
        out_step_err <= step_err_p0;
        out_wrap     <= wrap_p0;
      end else begin
        skid_valid <= 1'b1;
      end
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_to_gray_enc.sv
// Scoreboard bench for bin_to_gray_enc: stimulus pushes hand-computed
// expectations at acceptance, a forked monitor pops them on each transfer.
module tb_bin_to_gray_enc;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_bin = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_gray;
  logic         out_step_err;
  logic         out_wrap;
  logic [7:0]   err_count;

  logic         in_ready2;
  logic         out_valid2;
  logic [W-1:0] out_gray2;
  logic         out_step_err2;
  logic         out_wrap2;
  logic [1:0]   err_count2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];

  // Hand-written Gray codes for 0..15.
  logic [W-1:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

  bin_to_gray_enc #(.WIDTH(W), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
    .out_gray(out_gray), .out_step_err(out_step_err), .out_wrap(out_wrap),
    .err_count(err_count));

  bin_to_gray_enc #(.WIDTH(W), .ERRW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_bin(in_bin), .out_valid(out_valid2), .out_ready(out_ready),
    .out_gray(out_gray2), .out_step_err(out_step_err2), .out_wrap(out_wrap2),
    .err_count(err_count2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {28'd0, out_gray}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_gray", {28'd0, out_gray}, {28'd0, e[W+1:2]});
          chk("out_step_err", {31'd0, out_step_err}, {31'd0, e[1]});
          chk("out_wrap", {31'd0, out_wrap}, {31'd0, e[0]});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat; returns after the accepting edge with the cycles stalled.
  task automatic send(input logic [W-1:0] b, input logic [W-1:0] g,
                      input logic e, input logic w, output int stalls);
    bit ok;
    in_valid = 1'b1;
    in_bin   = b;
    stalls   = 0;
    ok       = 1'b0;
    while (!ok && stalls <= 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else stalls++;
      if (!ok) @(posedge clk);
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back({g, e, w});
      #1;
    end else begin
      chk("accept_timeout", 32'(stalls), 32'd0);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    fork
      monitor();
    join_none

    // Reset state
    #1 rst = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_gray", {28'd0, out_gray}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_flags", {30'd0, out_step_err, out_wrap}, 32'd0);

    // Single beat 5
    out_ready = 1'b1;
    send(4'd5, 4'b0111, 1'b0, 1'b0, st);
    @(negedge clk);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_gray", {28'd0, out_gray}, 32'h7);
    chk("single_errcnt", {24'd0, err_count}, 32'd0);
    drain();

    // Full-rate stream 0..15 then 0
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      send(W'(i % 16), gray_tbl[i % 16], 1'b0, (i == 16), st);
      chk("stream_stall", 32'(st), 32'd0);
    end
    drain();
    chk("stream_errcnt", {24'd0, err_count}, 32'd0);

    // Backpressure with skid
    do_reset();
    send(4'd0, 4'b0000, 1'b0, 1'b0, st);
    send(4'd1, 4'b0001, 1'b0, 1'b0, st);
    send(4'd2, 4'b0011, 1'b0, 1'b0, st);
    tick();
    out_ready = 1'b0;
    send(4'd3, 4'b0010, 1'b0, 1'b0, st);
    send(4'd4, 4'b0110, 1'b0, 1'b0, st);
    @(negedge clk);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_gray", {28'd0, out_gray}, 32'h2);
    tick();
    tick();
    @(negedge clk);
    chk("bp_hold_gray2", {28'd0, out_gray}, 32'h2);
    chk("bp_in_ready_low2", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    drain();

    // Step errors and both wrap directions
    do_reset();
    send(4'd3, 4'b0010, 1'b0, 1'b0, st);
    send(4'd5, 4'b0111, 1'b1, 1'b0, st);
    send(4'd5, 4'b0111, 1'b1, 1'b0, st);
    send(4'd4, 4'b0110, 1'b0, 1'b0, st);
    chk("step_errcnt", {24'd0, err_count}, 32'd2);
    send(4'd0, 4'b0000, 1'b1, 1'b0, st);
    send(4'd15, 4'b1000, 1'b0, 1'b1, st);
    send(4'd14, 4'b1001, 1'b0, 1'b0, st);
    chk("step_errcnt2", {24'd0, err_count}, 32'd3);
    drain();

    // Saturation of a 2-bit counter
    do_reset();
    send(4'd0, 4'b0000, 1'b0, 1'b0, st);
    send(4'd5, 4'b0111, 1'b1, 1'b0, st);
    send(4'd10, 4'b1111, 1'b1, 1'b0, st);
    send(4'd0, 4'b0000, 1'b1, 1'b0, st);
    chk("sat_cnt_at3", {30'd0, err_count2}, 32'd3);
    send(4'd7, 4'b0100, 1'b1, 1'b0, st);
    send(4'd2, 4'b0011, 1'b1, 1'b0, st);
    chk("sat_cnt_hold", {30'd0, err_count2}, 32'd3);
    chk("sat_wide_cnt", {24'd0, err_count}, 32'd5);
    drain();

    // Asynchronous reset with the skid full
    do_reset();
    out_ready = 1'b0;
    send(4'd1, 4'b0001, 1'b0, 1'b0, st);
    send(4'd7, 4'b0100, 1'b1, 1'b0, st);
    @(negedge clk);
    chk("mid_skid_full", {31'd0, in_ready}, 32'd0);
    chk("mid_errcnt", {24'd0, err_count}, 32'd1);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_errcnt", {24'd0, err_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_ready_after", {31'd0, in_ready}, 32'd1);
    send(4'd9, 4'b1101, 1'b0, 1'b0, st);
    @(negedge clk);
    chk("mid_next_gray", {28'd0, out_gray}, 32'hD);
    chk("mid_next_err", {31'd0, out_step_err}, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
